// File: rtl/fib_pkg.sv
// Shared types and parameter defaults for the Fibonacci generator.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package fib_pkg;

  // Default result width and index width.
  localparam int unsigned FIB_WIDTH_DEF     = 32;
  localparam int unsigned FIB_IDX_WIDTH_DEF = 6;

  // Controller states.
  //   IDLE   : waiting for a request
  //   CALC   : single mode, stepping silently towards F(n)
  //   OUT    : single mode, presenting F(n)
  //   STREAM : stream mode, presenting F(k) and stepping on each handshake
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    CALC   = 2'd1,
    OUT    = 2'd2,
    STREAM = 2'd3
  } fib_state_e;

endpackage

// File: rtl/fib_step.sv
// Fibonacci term pair a=F(k), b=F(k+1) with sticky per-term overflow bits.
// Latency: one advance per enabled cycle; load returns the pair to F(0),F(1) in one cycle.
// Backpressure: none; the caller only asserts adv_i when a step is wanted.
module fib_step #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load_i,
  input  logic             adv_i,
  output logic [WIDTH-1:0] a_o,
  output logic             a_ovf_o
);

  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic             a_ovf_q, a_ovf_d;
  logic             b_ovf_q, b_ovf_d;

  // One extra bit captures the carry-out of the wrapping addition.
  logic [WIDTH:0]   sum;

  assign sum = {1'b0, a_q} + {1'b0, b_q};

  // Next pair: load has priority so a fresh request always starts from F(0),F(1).
  // The overflow of b is sticky: once any term exceeded WIDTH, every later
  // term does too, even if the wrapped sum happens not to carry.
  always_comb begin
    a_d     = a_q;
    b_d     = b_q;
    a_ovf_d = a_ovf_q;
    b_ovf_d = b_ovf_q;
    if (load_i) begin
      a_d     = '0;
      b_d     = {{(WIDTH-1){1'b0}}, 1'b1};
      a_ovf_d = 1'b0;
      b_ovf_d = 1'b0;
    end else if (adv_i) begin
      a_d     = b_q;
      b_d     = sum[WIDTH-1:0];
      a_ovf_d = b_ovf_q;
      b_ovf_d = a_ovf_q | b_ovf_q | sum[WIDTH];
    end
  end

  // Pair registers; reset value is the F(0),F(1) starting point.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_q     <= '0;
      b_q     <= {{(WIDTH-1){1'b0}}, 1'b1};
      a_ovf_q <= 1'b0;
      b_ovf_q <= 1'b0;
    end else begin
      a_q     <= a_d;
      b_q     <= b_d;
      a_ovf_q <= a_ovf_d;
      b_ovf_q <= b_ovf_d;
    end
  end

  assign a_o     = a_q;
  assign a_ovf_o = a_ovf_q;

endmodule

// File: rtl/fib_gen.sv
// Fibonacci generator: single result F(n) or stream F(0)..F(n) with per-beat overflow.
// Latency: single mode presents F(n) n cycles after the sampling edge (n=0: right after it); stream beat 0 right after it.
// Backpressure: out_ready low holds the current beat stable; stream steps only on a handshake.
module fib_gen
  import fib_pkg::*;
#(
  parameter int unsigned WIDTH     = FIB_WIDTH_DEF,
  parameter int unsigned IDX_WIDTH = FIB_IDX_WIDTH_DEF
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [IDX_WIDTH-1:0] n,
  input  logic                 stream,
  output logic                 busy,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [WIDTH-1:0]     result,
  output logic [IDX_WIDTH-1:0] index,
  output logic                 overflow,
  output logic                 out_last,
  output logic                 done
);

  fib_state_e           state_q, state_d;
  logic [IDX_WIDTH-1:0] k_q, k_d;
  logic [IDX_WIDTH-1:0] n_q, n_d;
  logic                 done_q, done_d;

  logic                 step_load;
  logic                 step_adv;
  logic [WIDTH-1:0]     a_val;
  logic                 a_ovf;

  // k+1 computed one bit wider so the k==n test cannot alias when n is the
  // largest representable index.
  logic [IDX_WIDTH:0]   k_inc;
  logic                 k_at_n;
  logic                 hs;

  assign k_inc  = {1'b0, k_q} + (IDX_WIDTH+1)'(1);
  assign k_at_n = (k_q == n_q);
  assign hs     = out_valid & out_ready;

  fib_step #(
    .WIDTH (WIDTH)
  ) u_step (
    .clk     (clk),
    .rst     (rst),
    .load_i  (step_load),
    .adv_i   (step_adv),
    .a_o     (a_val),
    .a_ovf_o (a_ovf)
  );

  // Next-state, counter and term-pair control for the request FSM.
  always_comb begin
    state_d   = state_q;
    k_d       = k_q;
    n_d       = n_q;
    done_d    = 1'b0;
    step_load = 1'b0;
    step_adv  = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          n_d       = n;
          k_d       = '0;
          step_load = 1'b1;
          if (stream) begin
            state_d = STREAM;
          end else if (n == '0) begin
            state_d = OUT;
          end else begin
            state_d = CALC;
          end
        end
      end
      CALC: begin
        step_adv = 1'b1;
        k_d      = k_inc[IDX_WIDTH-1:0];
        if (k_inc == {1'b0, n_q}) begin
          state_d = OUT;
        end
      end
      OUT: begin
        if (hs) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end
      end
      STREAM: begin
        if (hs) begin
          if (k_at_n) begin
            state_d = IDLE;
            done_d  = 1'b1;
          end else begin
            step_adv = 1'b1;
            k_d      = k_inc[IDX_WIDTH-1:0];
          end
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Control registers; reset aborts any request without a done pulse.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      k_q     <= '0;
      n_q     <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      k_q     <= k_d;
      n_q     <= n_d;
      done_q  <= done_d;
    end
  end

  // Output view of the current beat; data outputs read zero when no beat is offered.
  always_comb begin
    busy      = (state_q != IDLE);
    out_valid = (state_q == OUT) || (state_q == STREAM);
    result    = out_valid ? a_val : '0;
    index     = out_valid ? k_q   : '0;
    overflow  = out_valid & a_ovf;
    out_last  = (state_q == OUT) || ((state_q == STREAM) && k_at_n);
    done      = done_q;
  end

endmodule
